// File: rtl/debounce_event_ctrl.sv
// debounce_event_ctrl
// Multi-channel button front end: each raw input is synchronized, debounced
// against a runtime-programmable stable-cycle count, and every committed
// level change becomes a press/release event. A round-robin arbiter shares
// one registered event slot between all channels.
//
// Event port handshake: o_event_valid/o_event_channel/o_event_press form a
// registered slot. An event transfers on a rising edge where o_event_valid
// and i_event_ready are both 1. While o_event_valid=1 and i_event_ready=0 the
// channel and press fields are held unchanged. The slot is refilled in the
// same edge that consumes the current event, so one event per cycle flows.
module debounce_event_ctrl #(
  parameter int NUM_CHANNELS           = 4,
  parameter int DEBOUNCE_COUNTER_WIDTH = 16
) (
  input  logic                              i_clock,
  input  logic                              i_reset_n,
  input  logic [DEBOUNCE_COUNTER_WIDTH-1:0] i_debounce_counter,
  input  logic [NUM_CHANNELS-1:0]           i_bouncing_signals,
  output logic [NUM_CHANNELS-1:0]           o_debounced_signals,
  output logic                              o_event_valid,
  input  logic                              i_event_ready,
  output logic [$clog2(NUM_CHANNELS)-1:0]   o_event_channel,
  output logic                              o_event_press,
  output logic                              o_overflow,
  input  logic                              i_overflow_clear
);

  localparam int CW   = DEBOUNCE_COUNTER_WIDTH;
  localparam int CW1  = CW + 1;
  localparam int CH_W = $clog2(NUM_CHANNELS);
  localparam int SW   = CH_W + 1;

  // Synchronizer, debounce and event bookkeeping state
  logic [NUM_CHANNELS-1:0] sync1;
  logic [NUM_CHANNELS-1:0] sync2;
  logic [NUM_CHANNELS-1:0] stable;
  logic [CW-1:0]           count_q [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] pending;
  logic [NUM_CHANNELS-1:0] ev_type;
  logic [CH_W-1:0]         rr_ptr;

  // Combinational decisions for the current cycle
  logic [CW-1:0]           d_eff;
  logic [NUM_CHANNELS-1:0] commit;
  logic                    slot_free;
  logic                    load_found;
  logic                    load_en;
  logic [CH_W-1:0]         load_ch;
  logic [SW-1:0]           scan_idx;
  logic [NUM_CHANNELS-1:0] load_mask;
  logic                    overflow_hit;

  assign o_debounced_signals = stable;

  // Two-flop synchronizer for the asynchronous raw inputs
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i_bouncing_signals;
      sync2 <= sync1;
    end
  end

  // A threshold of zero would commit without any filtering; treat it as one
  always_comb begin
    d_eff = (i_debounce_counter == '0) ? CW'(1) : i_debounce_counter;
  end

  // A channel commits when this cycle completes d_eff consecutive differing samples
  always_comb begin
    commit = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if ((sync2[ch] != stable[ch]) &&
          (({1'b0, count_q[ch]} + CW1'(1)) >= {1'b0, d_eff})) begin
        commit[ch] = 1'b1;
      end
    end
  end

  // Per-channel debounce counters and committed levels
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stable <= '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        count_q[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        if (sync2[ch] == stable[ch]) begin
          count_q[ch] <= '0;
        end else if (commit[ch]) begin
          stable[ch]  <= sync2[ch];
          count_q[ch] <= '0;
        end else begin
          count_q[ch] <= count_q[ch] + CW'(1);
        end
      end
    end
  end

  // Round-robin pick: first pending channel at or after rr_ptr, wrapping
  always_comb begin
    load_found = 1'b0;
    load_ch    = '0;
    scan_idx   = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      scan_idx = {1'b0, rr_ptr} + SW'(i);
      if (scan_idx >= SW'(NUM_CHANNELS)) begin
        scan_idx = scan_idx - SW'(NUM_CHANNELS);
      end
      if (!load_found && pending[scan_idx[CH_W-1:0]]) begin
        load_found = 1'b1;
        load_ch    = scan_idx[CH_W-1:0];
      end
    end
  end

  // Slot availability, load decision and overwrite detection
  always_comb begin
    slot_free = !o_event_valid || i_event_ready;
    load_en   = slot_free && load_found;
    load_mask = '0;
    if (load_en) begin
      load_mask[load_ch] = 1'b1;
    end
    // A commit landing on a pending flag that is not leaving this cycle loses the older event
    overflow_hit = |(commit & pending & ~load_mask);
  end

  // Pending flags and their event types; a fresh commit wins over a same-cycle load
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pending <= '0;
      ev_type <= '0;
    end else begin
      pending <= (pending & ~load_mask) | commit;
      ev_type <= (ev_type & ~commit) | (sync2 & commit);
    end
  end

  // Registered event slot and round-robin pointer
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_event_valid   <= 1'b0;
      o_event_channel <= '0;
      o_event_press   <= 1'b0;
      rr_ptr          <= '0;
    end else if (slot_free) begin
      if (load_found) begin
        o_event_valid   <= 1'b1;
        o_event_channel <= load_ch;
        o_event_press   <= ev_type[load_ch];
        rr_ptr          <= (load_ch == CH_W'(NUM_CHANNELS - 1)) ? '0 : load_ch + CH_W'(1);
      end else begin
        o_event_valid   <= 1'b0;
      end
    end
  end

  // Sticky overflow flag; a new overwrite beats a same-cycle clear
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_overflow <= 1'b0;
    end else if (overflow_hit) begin
      o_overflow <= 1'b1;
    end else if (i_overflow_clear) begin
      o_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debounce_event_ctrl.sv
// Bench for debounce_event_ctrl: directed scenarios with literal expectations
// plus a history-based reference model compared on every falling edge.
module tb_debounce_event_ctrl;

  localparam int N  = 4;
  localparam int CW = 16;

  // Clock/reset and DUT connections
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] d = 16'd10;
  logic [N-1:0]  raw = '0;
  logic          ready = 1'b1;
  logic          ovf_clr = 1'b0;
  logic [N-1:0]  deb;
  logic          ev_valid;
  logic [1:0]    ev_ch;
  logic          ev_press;
  logic          ovf;

  always #5 clk = ~clk;

  debounce_event_ctrl #(.NUM_CHANNELS(N), .DEBOUNCE_COUNTER_WIDTH(CW)) dut (
    .i_clock             (clk),
    .i_reset_n           (rst_n),
    .i_debounce_counter  (d),
    .i_bouncing_signals  (raw),
    .o_debounced_signals (deb),
    .o_event_valid       (ev_valid),
    .i_event_ready       (ready),
    .o_event_channel     (ev_ch),
    .o_event_press       (ev_press),
    .o_overflow          (ovf),
    .i_overflow_clear    (ovf_clr)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw samples per edge, the value the filter sees per edge,
  // and an event store with a wrapping search pointer.
  logic [N-1:0] raw_hist[$];
  logic [N-1:0] seen_hist[$];
  logic [N-1:0] m_stable = '0;
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_type = '0;
  logic         m_valid = 1'b0;
  int           m_ch = 0;
  logic         m_press = 1'b0;
  int           m_ptr = 0;
  logic         m_ovf = 1'b0;

  task automatic model_reset();
    raw_hist.delete();
    seen_hist.delete();
    raw_hist.push_back('0);
    raw_hist.push_back('0);
    m_stable = '0; m_pend = '0; m_type = '0;
    m_valid = 1'b0; m_ch = 0; m_press = 1'b0; m_ptr = 0; m_ovf = 1'b0;
  endtask

  task automatic model_step();
    int deff;
    int streak;
    int pick;
    bit done;
    bit ovf_hit;
    logic [N-1:0] s;
    logic [N-1:0] com;
    deff = (d == 0) ? 1 : int'(d);
    // the filter sees the raw level from two edges ago
    s = raw_hist[raw_hist.size() - 2];
    seen_hist.push_back(s);
    com = '0;
    for (int ch = 0; ch < N; ch++) begin
      // length of the unbroken run of samples differing from the committed level
      streak = 0;
      done = 0;
      for (int k = seen_hist.size() - 1; k >= 0 && !done && streak < deff; k--) begin
        if (seen_hist[k][ch] != m_stable[ch]) streak++;
        else done = 1;
      end
      if (streak >= deff) com[ch] = 1'b1;
    end
    pick = -1;
    if (!m_valid || ready) begin
      for (int i = 0; i < N; i++) begin
        if (pick < 0 && m_pend[(m_ptr + i) % N]) pick = (m_ptr + i) % N;
      end
      if (pick >= 0) begin
        m_valid = 1'b1;
        m_ch = pick;
        m_press = m_type[pick];
        m_ptr = (pick + 1) % N;
        m_pend[pick] = 1'b0;
      end else begin
        m_valid = 1'b0;
      end
    end
    ovf_hit = 0;
    for (int ch = 0; ch < N; ch++) begin
      if (com[ch]) begin
        if (m_pend[ch]) ovf_hit = 1;
        m_pend[ch] = 1'b1;
        m_type[ch] = s[ch];
        m_stable[ch] = s[ch];
      end
    end
    if (ovf_hit) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    raw_hist.push_back(raw);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    check("cmp_debounced", deb, m_stable);
    check("cmp_valid", ev_valid, m_valid);
    check("cmp_overflow", ovf, m_ovf);
    if (m_valid) begin
      check("cmp_channel", ev_ch, m_ch);
      check("cmp_press", ev_press, m_press);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(3);
    check("reset_debounced", deb, 0);
    check("reset_valid", ev_valid, 0);
    check("reset_overflow", ovf, 0);
    check("reset_channel", ev_ch, 0);
    check("reset_press", ev_press, 0);
    rst_n = 1'b1;
    step(2);

    // 1: short glitch is filtered
    raw[0] = 1'b1; step(3);
    raw[0] = 1'b0; step(20);
    check("t1_debounced", deb, 0);
    check("t1_valid", ev_valid, 0);

    // 2: held press commits at edge 12, event on edge 13, then release
    raw[0] = 1'b1; step(11);
    check("t2_pre_commit", deb, 0);
    step(1);
    check("t2_commit", deb, 4'b0001);
    check("t2_no_event_yet", ev_valid, 0);
    step(1);
    check("t2_press_valid", ev_valid, 1);
    check("t2_press_ch", ev_ch, 0);
    check("t2_press_type", ev_press, 1);
    step(1);
    check("t2_consumed", ev_valid, 0);
    raw[0] = 1'b0; step(12);
    check("t2_release_commit", deb, 0);
    step(1);
    check("t2_release_ch", ev_ch, 0);
    check("t2_release_type", ev_press, 0);
    step(5);

    // 3: simultaneous rise/fall on ch1 and ch2, pointer wraps from 3
    raw[2:1] = 2'b11; step(12);
    check("t3_commit", deb, 4'b0110);
    step(1);
    check("t3_first_ch", ev_ch, 1);
    step(1);
    check("t3_second_ch", ev_ch, 2);
    step(1);
    check("t3_idle", ev_valid, 0);
    raw[2:1] = 2'b00; step(13);
    check("t3_fall_first_ch", ev_ch, 1);
    check("t3_fall_first_type", ev_press, 0);
    step(1);
    check("t3_fall_second_ch", ev_ch, 2);
    step(5);

    // 4: slot held by ch1, ch0 press then release overwrite the pending event
    ready = 1'b0;
    raw[1] = 1'b1; step(13);
    check("t4_held_ch", ev_ch, 1);
    raw[0] = 1'b1; step(12);
    raw[0] = 1'b0; step(12);
    check("t4_overflow", ovf, 1);
    check("t4_held_valid", ev_valid, 1);
    check("t4_held_ch_again", ev_ch, 1);
    check("t4_held_type", ev_press, 1);
    ready = 1'b1; step(1);
    check("t4_second_ch", ev_ch, 0);
    check("t4_second_type", ev_press, 0);
    step(1);
    ovf_clr = 1'b1; step(1);
    ovf_clr = 1'b0;
    check("t4_overflow_cleared", ovf, 0);
    step(3);

    // 5: D=0 behaves as D=1; then lowering D mid-count commits at once
    d = 16'd0;
    raw[3] = 1'b1; step(2);
    check("t5_pre_commit", deb[3], 0);
    step(1);
    check("t5_commit", deb[3], 1);
    step(1);
    check("t5_event_ch", ev_ch, 3);
    d = 16'd10;
    raw[2] = 1'b1; step(8);
    check("t5_lower_pre", deb[2], 0);
    d = 16'd4; step(1);
    check("t5_lower_commit", deb[2], 1);
    d = 16'd10; step(5);

    // 6: reset during a count with an event held in the slot
    ready = 1'b0;
    raw[1] = 1'b0; step(13);
    check("t6_held_valid", ev_valid, 1);
    raw[0] = 1'b1; step(5);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", ev_valid, 0);
    check("t6_rst_debounced", deb, 0);
    check("t6_rst_channel", ev_ch, 0);
    check("t6_rst_press", ev_press, 0);
    check("t6_rst_overflow", ovf, 0);
    raw = '0;
    ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step(30);
    check("t6_no_stale_event", ev_valid, 0);
    check("t6_debounced_idle", deb, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
